note_lane_scroller: RTL and testbench
=====================================

Name: note_lane_scroller

Overview:
- Downstream consumer of the scroll-offset generator: takes its `data_en`/`data` offset stream (0,4,8,12,16, gated by `map`) and keeps a 4-lane falling-note grid.
- Each time the offset wraps, one grid row is retired and a new pattern row is loaded.
- Player key presses against the bottom (hit) row are scored as hits; unplayed notes that fall off are counted as misses.
- Feeds the VGA renderer (`grid`, `y_offset`) and the score display (`score`, `combo`).

Parameters:
- LANES, 4, number of note lanes
- DEPTH, 8, grid rows; row 0 = hit row, row DEPTH-1 = entry row
- DATA_MAX, 16, offset value at which the upstream wraps
- SONG_ROWS, 64, pattern rows per song
- SCORE_W, 16, score/combo counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins/restarts a song
- map  in  1  scroll step enable (same signal driving upstream)
- data_en  in  1  upstream offset valid
- data  in  8  upstream scroll offset
- note_row  in  LANES  next pattern row, bit l = note in lane l
- row_req  out  1  pulse: pattern source must present next row
- key  in  LANES  debounced key levels, active-high
- grid  out  LANES*DEPTH  note bits, index r*LANES+l
- y_offset  out  8  registered copy of data for renderer
- score  out  SCORE_W  accumulated points
- combo  out  SCORE_W  consecutive hits since last miss
- hit  out  1  pulse on any scored hit
- miss  out  1  pulse on any missed note
- perfect  out  1  pulse on perfect hit (see Optional Feature)
- busy  out  1  high in RUN
- done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE. `grid`, `score`, `combo`, `y_offset`, `rows_loaded`, key history = 0. All pulses, `busy` and `done` = 0.
- Advance event A = `data_en & map & (data==DATA_MAX)`. This is the same edge on which the upstream wraps to 0.
- `y_offset` <= `data` on every cycle with `data_en`=1; holds otherwise.
- Key edge: `kp[l]` = `key[l]` & ~`key_d[l]`. `key_d` is registered every cycle in all states.
- States:
  - IDLE: `start` -> RUN, clearing `score`, `combo`, `grid` and `rows_loaded`.
  - RUN: scroll and score as below. When `rows_loaded==SONG_ROWS` and `grid`==0 -> DONE.
  - DONE: `done`=1, all counters frozen. `start` -> RUN with the same clears as from IDLE.
  - `start` while in RUN is ignored.
- Hit (RUN only): `kp[l]` & `grid[0][l]` -> clear that bit, `score` += 1 per lane hit, `combo` += 1 per lane hit, `hit`=1 for one cycle. `kp` on an empty lane: no effect.
- On A in RUN:
  - Rows shift down: row r <= row r+1.
  - Row DEPTH-1 <= `note_row` if `rows_loaded` < SONG_ROWS (then `rows_loaded`++), else 0.
  - Any bit still set in row 0 is a miss: `miss`=1 for one cycle, `combo` <= 0.
  - `row_req` pulses the cycle after A.
- `note_row` is sampled on the A edge. The source has ≥4 map steps after `row_req` to update it.
- Hit and A in the same cycle on the same lane: the hit wins. The note is scored and not counted as a miss; the shift happens as normal.
- Hit on one lane and miss on another in the same cycle: `score` gets the hit points, `combo` ends at 0.
- `score` and `combo` saturate at all-ones; no wrap-around.
- `map`=0: grid frozen, keys still score against row 0.
- A in IDLE/DONE: ignored, no `row_req`.
- `reset` asserted mid-song: full return to the reset state on the next edge.

Optional Feature:
- Macro: NOTE_LANE_PERFECT_EN.
- Defined: a hit with `y_offset` <= 4 awards 2 points instead of 1 and pulses `perfect` with `hit`. `combo` still +1 per lane.
- Undefined: every hit awards 1 point and `perfect` is tied to 0.

Test Plan:
- Reset, then `start` with `note_row`=4'b0001 constant, `map`=1 and `data` cycling 0..16. After 8 A events, `grid` row 0 = 0001 and `rows_loaded`=8. After the 9th A: `miss`=1, `combo`=0.
- Note in lane 2 at row 0, `key[2]` rising with `y_offset`=8 -> `hit`=1, `score`=1, `combo`=1, bit cleared. Holding `key` high for 5 more cycles gives no further score.
- `key[2]` rising in the same cycle as A with the lane-2 note in row 0 -> `hit`=1, `miss`=0, `score`=1.
- SONG_ROWS=4, all rows 4'b1111, no keys pressed -> 4 `miss` pulses, then `done`=1 after the grid empties. `start` -> `busy`=1, `score`=0.
- `score` preloaded to 16'hFFFF (force), one more hit -> `score` stays FFFF. `reset` in the middle of RUN -> next cycle `grid`=0, state IDLE.
- NOTE_LANE_PERFECT_EN defined, hit at `y_offset`=4 -> `score` +2, `perfect`=1. Hit at `y_offset`=12 -> `score` +1, `perfect`=0.

Source files
------------

// File: rtl/note_lane_scroller.sv
// note_lane_scroller: falling-note lane grid fed by the scroll-offset stream; optional perfect scoring under NOTE_LANE_PERFECT_EN
module note_lane_scroller #(
  parameter int LANES     = 4,
  parameter int DEPTH     = 8,
  parameter int DATA_MAX  = 16,
  parameter int SONG_ROWS = 64,
  parameter int SCORE_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     map,
  input  logic                     data_en,
  input  logic [7:0]               data,
  input  logic [LANES-1:0]         note_row,
  output logic                     row_req,
  input  logic [LANES-1:0]         key,
  output logic [LANES*DEPTH-1:0]   grid,
  output logic [7:0]               y_offset,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       combo,
  output logic                     hit,
  output logic                     miss,
  output logic                     perfect,
  output logic                     busy,
  output logic                     done
);
  localparam int NHW = $clog2(LANES + 1);
  localparam int RLW = $clog2(SONG_ROWS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [LANES-1:0] key_d, kp, row0, hits, row_in;
  logic [RLW-1:0] rows_loaded;
  logic [NHW-1:0] nh;
  logic [NHW:0] pts;
  logic [SCORE_W:0] score_sum, combo_sum;
  logic [SCORE_W-1:0] score_nx, combo_nx;
  logic [LANES*DEPTH-1:0] grid_nx;
  logic run, adv, restart, perf, miss_c;
  assign run = state == RUN;
  assign restart = start && state != RUN;
  assign adv = run && data_en && map && data == 8'(DATA_MAX);
  assign kp = key & ~key_d;
  assign row0 = grid[LANES-1:0];
  assign hits = run ? kp & row0 : '0;
`ifdef NOTE_LANE_PERFECT_EN
  assign perf = |hits && y_offset <= 8'd4;
`else
  assign perf = 1'b0;
`endif
  // count lanes hit this cycle
  always_comb begin
    nh = '0;
    for (int i = 0; i < LANES; i++) nh = nh + NHW'(hits[i]);
  end
  assign pts = perf ? {nh, 1'b0} : {1'b0, nh};
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(pts);
  assign combo_sum = {1'b0, combo} + (SCORE_W+1)'(nh);
  // a note hit on the shift edge is cleared first, so it never counts as a miss
  assign miss_c = adv && |(row0 & ~kp);
  assign score_nx = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign combo_nx = miss_c ? '0 : combo_sum[SCORE_W] ? '1 : combo_sum[SCORE_W-1:0];
  assign row_in = rows_loaded < RLW'(SONG_ROWS) ? note_row : '0;
  assign grid_nx = adv ? {row_in, grid[LANES*DEPTH-1:LANES]}
                       : {grid[LANES*DEPTH-1:LANES], row0 & ~kp};
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state: start ignored while running, finish once song loaded and grid drained
  always_comb begin
    state_nx = state;
    if (state != RUN) state_nx = start ? RUN : state;
    else state_nx = (rows_loaded == RLW'(SONG_ROWS) && grid == '0) ? DONE : RUN;
  end
  // state-decoded outputs
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // grid scroll, scoring and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      key_d <= '0;
      y_offset <= '0;
      grid <= '0;
      score <= '0;
      combo <= '0;
      rows_loaded <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      perfect <= 1'b0;
      row_req <= 1'b0;
    end else begin
      key_d <= key;
      if (data_en) y_offset <= data;
      hit <= 1'b0;
      miss <= 1'b0;
      perfect <= 1'b0;
      row_req <= 1'b0;
      if (restart) begin
        grid <= '0;
        score <= '0;
        combo <= '0;
        rows_loaded <= '0;
      end else if (run) begin
        grid <= grid_nx;
        score <= score_nx;
        combo <= combo_nx;
        hit <= |hits;
        miss <= miss_c;
        perfect <= perf;
        row_req <= adv;
        if (adv && rows_loaded < RLW'(SONG_ROWS)) rows_loaded <= rows_loaded + RLW'(1);
      end
    end
  end
endmodule

// File: tb/tb_note_lane_scroller.sv
// tb_note_lane_scroller: directed vector bench for note_lane_scroller
module tb_note_lane_scroller;
`ifdef NOTE_LANE_PERFECT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, start, start2, map, data_en;
  logic [7:0] data;
  logic [3:0] note_row, note_row2, key, key2;
  logic [31:0] grid, grid2;
  logic [7:0] y_offset, y_offset2;
  logic [15:0] score, score2, combo, combo2;
  logic row_req, row_req2, hit, hit2, miss, miss2, perfect, perfect2, busy, busy2, done, done2;
  int checks = 0, errors = 0, ph = 0, misses = 0;

  note_lane_scroller u_dut (
    .clk(clk), .reset(reset), .start(start), .map(map), .data_en(data_en), .data(data),
    .note_row(note_row), .row_req(row_req), .key(key), .grid(grid), .y_offset(y_offset),
    .score(score), .combo(combo), .hit(hit), .miss(miss), .perfect(perfect), .busy(busy), .done(done));

  note_lane_scroller #(.SONG_ROWS(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .map(map), .data_en(data_en), .data(data),
    .note_row(note_row2), .row_req(row_req2), .key(key2), .grid(grid2), .y_offset(y_offset2),
    .score(score2), .combo(combo2), .hit(hit2), .miss(miss2), .perfect(perfect2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] key;
    logic hit, miss, perf;
    int score, score_p, combo;
    logic [3:0] row0;
  } vec_t;
  vec_t vt[35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    data = 8'(4 * ph);
    @(posedge clk);
    #1;
    ph = (ph + 1) % 5;
  endtask

  initial begin
    logic [3:0] pat [8];
    pat = '{4'h1, 4'h4, 4'h0, 4'h4, 4'h2, 4'h9, 4'h0, 4'h1};
    for (int i = 0; i < 4; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'h1};
    vt[4] = '{4'h0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 4'h4};
    for (int i = 5; i < 8; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'h4};
    vt[8] = '{4'h4, 1'b1, 1'b0, 1'b0, 1, 1, 1, 4'h0};
    for (int i = 9; i < 14; i++) vt[i] = '{4'h4, 1'b0, 1'b0, 1'b0, 1, 1, 1, 4'h0};
    vt[14] = '{4'h0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 4'h4};
    for (int i = 15; i < 19; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 4'h4};
    vt[19] = '{4'h4, 1'b1, 1'b0, 1'b0, 2, 2, 2, 4'h2};
    for (int i = 20; i < 22; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 2, 2, 2, 4'h2};
    vt[22] = '{4'h2, 1'b1, 1'b0, 1'b1, 3, 4, 3, 4'h0};
    vt[23] = '{4'h2, 1'b0, 1'b0, 1'b0, 3, 4, 3, 4'h0};
    vt[24] = '{4'h0, 1'b0, 1'b0, 1'b0, 3, 4, 3, 4'h9};
    for (int i = 25; i < 29; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 3, 4, 3, 4'h9};
    vt[29] = '{4'h1, 1'b1, 1'b1, 1'b0, 4, 5, 0, 4'h0};
    for (int i = 30; i < 34; i++) vt[i] = '{4'h0, 1'b0, 1'b0, 1'b0, 4, 5, 0, 4'h0};
    vt[34] = '{4'h0, 1'b0, 1'b0, 1'b0, 4, 5, 0, 4'h1};

    reset = 1'b1; start = 1'b0; start2 = 1'b0; map = 1'b0; data_en = 1'b0;
    note_row = 4'h0; note_row2 = 4'hF; key = 4'h0; key2 = 4'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_grid", grid, 32'h0);
    chk("rst_score", score, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_pulses", {hit, miss, perfect, row_req}, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 32'h1);
    ph = 0; map = 1'b1; data_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      note_row = pat[k];
      for (int s = 0; s < 5; s++) tick();
    end
    note_row = 4'h0;
    chk("fill_grid", grid, 32'h10924041);
    chk("fill_rows_loaded", 32'(u_dut.rows_loaded), 32'd8);
    chk("fill_row_req", row_req, 32'h1);
    chk("fill_y_offset", y_offset, 32'd16);

    for (int i = 0; i < 35; i++) begin
      key = vt[i].key;
      tick();
      chk($sformatf("v%0d_hit", i), hit, vt[i].hit);
      chk($sformatf("v%0d_miss", i), miss, vt[i].miss);
      chk($sformatf("v%0d_perfect", i), perfect, PERF & vt[i].perf);
      chk($sformatf("v%0d_score", i), score, PERF ? vt[i].score_p : vt[i].score);
      chk($sformatf("v%0d_combo", i), combo, vt[i].combo);
      chk($sformatf("v%0d_row0", i), grid[3:0], vt[i].row0);
      chk($sformatf("v%0d_row_req", i), row_req, i % 5 == 4);
    end
    chk("idle2_grid", grid2, 32'h0);
    chk("idle2_rows", 32'(u_dut2.rows_loaded), 32'h0);

    force u_dut.score = 16'hFFFF;
    #1;
    release u_dut.score;
    key = 4'h1; tick();
    chk("sat_hit", hit, 32'h1);
    chk("sat_score", score, 32'hFFFF);
    chk("sat_combo", combo, 32'h1);
    tick();
    chk("sat_hold_hit", hit, 32'h0);
    chk("sat_hold_score", score, 32'hFFFF);
    key = 4'h0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_grid", grid, 32'h0);
    chk("midrst_busy", busy, 32'h0);
    chk("midrst_done", done, 32'h0);
    chk("midrst_score", score, 32'h0);
    chk("midrst_combo", combo, 32'h0);

    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("s2_busy", busy2, 32'h1);
    for (int n = 0; n < 150 && !done2; n++) begin
      tick();
      if (miss2) misses++;
    end
    chk("s2_done", done2, 32'h1);
    chk("s2_misses", misses, 32'd4);
    chk("s2_grid", grid2, 32'h0);
    chk("s2_busy_off", busy2, 32'h0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("s2_restart_busy", busy2, 32'h1);
    chk("s2_restart_done", done2, 32'h0);
    chk("s2_restart_score", score2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
